// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl: per-frame position generator for the rectangle draw stage.
//   The rectangle follows the mouse, drops under gravity on a left click,
//   bounces on the floor with damping and then comes to rest.
// Latency: xpos/ypos/state_o update on the clock edge that first samples vsync
//   high (one cycle after the rising edge reaches the input).
// Backpressure: none; outputs are level signals held constant between frame ticks.
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   vsync                  frame timing; rising edge is the frame tick
//   mouse_xpos/ypos/left   mouse position and left button level (clk domain)
//   xpos, ypos             registered top-left corner of the rectangle
//   state_o                debug view of the motion state (0 IDLE .. 3 REST)
module rect_motion_ctl #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int RECT_W     = 64,
  parameter int RECT_H     = 64,
  parameter int G          = 1,
  parameter int V_MAX      = 32,
  parameter int DAMP_SHIFT = 1,
  parameter int V_STOP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state_o
);

  localparam logic [12:0] X_MAX   = 13'(SCREEN_W - RECT_W - 1);
  localparam logic [12:0] Y_FLOOR = 13'(SCREEN_H - RECT_H - 1);
  localparam logic [12:0] G13     = 13'(G);
  localparam logic [5:0]  G6      = 6'(G);
  localparam logic [12:0] VMAX13  = 13'(V_MAX);
  localparam logic [5:0]  VMAX6   = 6'(V_MAX);
  localparam logic [5:0]  VSTOP6  = 6'(V_STOP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
    BOUNCE = 2'd2,
    REST   = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  vel;
  logic        vsync_q;
  logic        left_q;
  logic        pend;

  logic        tick;
  logic        press;
  logic        take_press;
  logic [11:0] mx_clamp;
  logic [11:0] my_clamp;
  logic [12:0] fall_ny;
  logic        fall_hit;
  logic [5:0]  fall_vb;
  logic [12:0] vel_inc;
  logic [5:0]  fall_vel;
  logic [11:0] bnc_y;
  logic [5:0]  bnc_vel;

  assign tick    = vsync & ~vsync_q;
  assign press   = mouse_left & ~left_q;
  // A press landing on the tick cycle has not reached pend yet, so fold it in here.
  assign take_press = pend | press;
  assign state_o = state;

  always_comb begin
    mx_clamp = ({1'b0, mouse_xpos} > X_MAX)   ? X_MAX[11:0]   : mouse_xpos;
    my_clamp = ({1'b0, mouse_ypos} > Y_FLOOR) ? Y_FLOOR[11:0] : mouse_ypos;

    // Falling: 13-bit sum so a large step past the floor cannot wrap.
    fall_ny  = {1'b0, ypos} + {7'b0, vel};
    fall_hit = (fall_ny >= Y_FLOOR);
    fall_vb  = vel >> DAMP_SHIFT;
    vel_inc  = {7'b0, vel} + G13;
    fall_vel = (vel_inc > VMAX13) ? VMAX6 : vel_inc[5:0];

    // Rising: both position and speed clamp at zero instead of underflowing.
    bnc_y    = (ypos > {6'b0, vel}) ? (ypos - {6'b0, vel}) : 12'd0;
    bnc_vel  = (vel > G6) ? (vel - G6) : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      xpos    <= '0;
      ypos    <= '0;
      vel     <= '0;
      vsync_q <= 1'b0;
      left_q  <= 1'b0;
      pend    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      left_q  <= mouse_left;

      // pend is consumed by every tick, whatever the state makes of it.
      if (tick)
        pend <= 1'b0;
      else if (press)
        pend <= 1'b1;

      if (tick) begin
        case (state)
          IDLE: begin
            xpos <= mx_clamp;
            ypos <= my_clamp;
            if (take_press) begin
              state <= FALL;
              vel   <= '0;
            end
          end

          FALL: begin
            if (fall_hit) begin
              ypos <= Y_FLOOR[11:0];
              if (fall_vb < VSTOP6) begin
                state <= REST;
                vel   <= '0;
              end else begin
                state <= BOUNCE;
                vel   <= fall_vb;
              end
            end else begin
              ypos <= fall_ny[11:0];
              vel  <= fall_vel;
            end
          end

          BOUNCE: begin
            ypos <= bnc_y;
            vel  <= bnc_vel;
            // Apex reached: start falling again from zero speed.
            if (bnc_vel == 6'd0)
              state <= FALL;
          end

          REST: begin
            if (take_press) begin
              state <= IDLE;
              xpos  <= mx_clamp;
              ypos  <= my_clamp;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rect_motion_ctl.sv
// tb_rect_motion_ctl: self-checking bench for rect_motion_ctl.
//   Frame-level vector table, hand sequences for tick/press/reset corners,
//   then randomized stimulus compared every cycle against a reference model.
module tb_rect_motion_ctl;

  localparam int X_MAX   = 800 - 64 - 1;
  localparam int Y_FLOOR = 600 - 64 - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  state_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rect_motion_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos),
    .state_o    (state_o)
  );

  // ---------------- reference model (frame-level rules, integer arithmetic)
  typedef struct {
    int st;
    int x;
    int y;
    int v;
    bit pend;
    bit vsq;
    bit lq;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c, input logic r, input logic vs,
                                    input logic ml, input logic [11:0] mx,
                                    input logic [11:0] my);
    mdl_t n;
    bit   t, p, took;
    int   vb;
    n = c;
    if (r) begin
      n = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      return n;
    end
    t    = vs && !c.vsq;
    p    = ml && !c.lq;
    took = c.pend || p;
    n.vsq = vs;
    n.lq  = ml;
    if (p) n.pend = 1'b1;
    if (t) begin
      n.pend = 1'b0;
      case (c.st)
        0: begin
          n.x = imin(int'(mx), X_MAX);
          n.y = imin(int'(my), Y_FLOOR);
          if (took) begin n.st = 1; n.v = 0; end
        end
        1: begin
          if (c.y + c.v >= Y_FLOOR) begin
            n.y = Y_FLOOR;
            vb  = c.v / 2;
            if (vb < 2) begin n.st = 3; n.v = 0; end
            else        begin n.st = 2; n.v = vb; end
          end else begin
            n.y = c.y + c.v;
            n.v = imin(c.v + 1, 32);
          end
        end
        2: begin
          n.y = (c.y > c.v) ? c.y - c.v : 0;
          n.v = (c.v > 1) ? c.v - 1 : 0;
          if (n.v == 0) n.st = 1;
        end
        default: begin
          if (took) begin
            n.st = 0;
            n.x  = imin(int'(mx), X_MAX);
            n.y  = imin(int'(my), Y_FLOOR);
          end
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= mdl_next(m, rst, vsync, mouse_left, mouse_xpos, mouse_ypos);

  // ---------------- checking helpers
  task automatic chk(input string nm, input int ex, input int ey, input int est);
    n_chk++;
    if (xpos !== 12'(ex) || ypos !== 12'(ey) || state_o !== 2'(est)) begin
      n_err++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d, want x=%0d y=%0d st=%0d",
               nm, xpos, ypos, state_o, ex, ey, est);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic frame();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic click();
    mouse_left = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int mx;
    int my;
    bit pr;
    int ex;
    int ey;
    int est;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;

    tbl = '{
      '{100, 200, 1'b0, 100, 200, 0},
      '{100, 200, 1'b0, 100, 200, 0},
      '{900, 700, 1'b0, 735, 535, 0},
      '{300, 530, 1'b1, 300, 530, 1},
      '{300, 530, 1'b0, 300, 530, 1},
      '{300, 530, 1'b0, 300, 531, 1},
      '{300, 530, 1'b0, 300, 533, 1},
      '{300, 530, 1'b0, 300, 535, 3},
      '{ 50,  60, 1'b0, 300, 535, 3},
      '{ 50,  60, 1'b1,  50,  60, 0},
      '{ 10,   0, 1'b1,  10,   0, 1}
    };

    rst = 1'b1; vsync = 1'b0; mouse_left = 1'b0;
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      mouse_xpos = 12'(tbl[i].mx);
      mouse_ypos = 12'(tbl[i].my);
      if (tbl[i].pr) click();
      frame();
      chk($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].est);
    end

    // Fall from the top: speed saturates, impact at 32 bounces at 16.
    n = 0;
    while (state_o != 2'd2 && n < 60) begin
      frame();
      n++;
    end
    chk_val("impact_frames", n, 34);
    chk("impact", 10, Y_FLOOR, 2);
    click();                       // ignored while bouncing
    frame();
    chk("bounce1", 10, 519, 2);
    repeat (14) frame();
    chk("bounce15", 10, 400, 2);
    frame();
    chk("apex", 10, 399, 1);

    // Long vsync high: one update per rising edge only.
    click();                       // ignored while falling
    vsync = 1'b1;
    @(negedge clk);
    chk("vs_edge1", 10, 399, 1);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    chk("vs_edge2", 10, 400, 1);
    repeat (8) @(negedge clk);
    chk("vs_hold_hi", 10, 400, 1);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    chk("vs_hold_lo", 10, 400, 1);

    // Reset in the middle of the second bounce.
    n = 0;
    while (state_o != 2'd2 && n < 60) begin
      frame();
      n++;
    end
    chk_val("bounce2_state", int'(state_o), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_bounce", 0, 0, 0);
    rst = 1'b0;
    mouse_xpos = 12'd20; mouse_ypos = 12'd30;
    @(negedge clk);

    // Press edge on the tick cycle counts for that tick.
    mouse_left = 1'b1; vsync = 1'b1;
    @(negedge clk);
    chk("press_at_tick", 20, 30, 1);
    mouse_left = 1'b0; vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Button released on the tick cycle: the earlier press still counts.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mouse_left = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0; vsync = 1'b1;
    @(negedge clk);
    chk("release_at_tick", 20, 30, 1);
    vsync = 1'b0;
    @(negedge clk);

    // vsync already high on the first cycle out of reset ticks immediately.
    rst = 1'b1; vsync = 1'b1;
    mouse_xpos = 12'd44; mouse_ypos = 12'd55;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("tick_after_rst", 44, 55, 0);
    vsync = 1'b0;
    @(negedge clk);

    // Randomized run against the model, checked every cycle.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      if ($urandom_range(0, 11) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 40) == 0) begin
        mouse_xpos = 12'($urandom_range(0, 1023));
        mouse_ypos = 12'($urandom_range(0, 1023));
      end
      rst = ($urandom_range(0, 799) == 0);
      @(negedge clk);
      chk("random", m.x, m.y, m.st);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
